// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_pkg
//  Purpose  : Shared types and constants for the instruction fetch stage:
//             datapath width, default NOP encoding, fetch FSM state encoding
//             and the {pc, instr} buffer entry layout.
//  Revision : 1.0  initial release
// ============================================================================
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no request on the bus
    ST_WAIT = 2'd1,  // request outstanding, data will be kept
    ST_DROP = 2'd2   // request outstanding, data will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_if
//  Purpose  : Instruction memory req/ack handshake.
//  Signals  : IMEM_req  - request valid, held until IMEM_ack
//             IMEM_addr - word address, stable while IMEM_req is high
//             IMEM_ack  - one-cycle acknowledge, IMEM_data valid with it
//             IMEM_data - returned instruction word
//  Modports : master (fetch stage), slave (instruction memory)
//  Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_if;

  logic                               IMEM_req;
  logic [instr_fetch_pkg::XLEN-1:0]   IMEM_addr;
  logic                               IMEM_ack;
  logic [instr_fetch_pkg::XLEN-1:0]   IMEM_data;

  modport master (
    output IMEM_req,
    output IMEM_addr,
    input  IMEM_ack,
    input  IMEM_data
  );

  modport slave (
    input  IMEM_req,
    input  IMEM_addr,
    output IMEM_ack,
    output IMEM_data
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Synchronous FIFO holding fetched {pc, instr} entries.
//             Flush has priority over push and pop. Push into a full FIFO
//             and pop from an empty FIFO are ignored.
//  Ports    : i_clk, i_rst      - clock, synchronous active-high reset
//             i_flush           - empty the FIFO
//             i_push, i_wdata   - write an entry
//             i_pop             - drop the head entry
//             o_rdata           - head entry (undefined content when empty)
//             o_count           - occupancy, 0..DEPTH
//             o_full, o_empty   - occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,   // power of two, >= 2
  parameter int unsigned WIDTH = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == DEPTH_C);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  assign do_push = i_push && !o_full && !i_flush;
  assign do_pop  = i_pop && !o_empty && !i_flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: it is only observed through count_q.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Instruction fetch stage. Holds the fetch PC, issues one word
//             request at a time to instruction memory, buffers returned
//             words in a small FIFO and presents them to decode. Handles
//             decode stall and redirect (branch / jump / exception / trap).
//  Ports    : i_clk, i_rst     - clock, synchronous active-high reset
//             imem             - instruction memory handshake (master)
//             i_Stall          - decode cannot accept this cycle
//             i_Redirect       - flush and restart at i_RedirectPC
//             i_RedirectPC     - new target, bits [1:0] ignored
//             o_Instr, o_PC    - head entry (NOP_INSTR / 0 when empty)
//             o_Valid          - head entry valid
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  instr_fetch_if.master    imem,
  input  logic             i_Stall,
  input  logic             i_Redirect,
  input  logic [XLEN-1:0]  i_RedirectPC,
  output logic [XLEN-1:0]  o_Instr,
  output logic [XLEN-1:0]  o_PC,
  output logic             o_Valid
);

  localparam int unsigned   CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q;

  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   count_after;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic            ack_keep;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] addr_inc;
  fetch_entry_t    head, wentry;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^i_RedirectPC[1:0];

  assign redirect_pc = word_align(i_RedirectPC);
  assign addr_inc    = addr_q + 32'd4;

  // An ack is only kept when the outstanding request still belongs to the
  // current instruction stream and no redirect arrives with it.
  assign ack_keep = (state_q == ST_WAIT) && imem.IMEM_ack && !i_Redirect;
  assign push     = ack_keep;
  assign pop      = !fifo_empty && !i_Stall && !i_Redirect;

  // Occupancy after this cycle's push and pop; decides back-to-back issue.
  assign count_after = fifo_count + {{(CW-1){1'b0}}, push}
                                  - {{(CW-1){1'b0}}, pop};

  assign wentry.pc    = addr_q;
  assign wentry.instr = imem.IMEM_data;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_Redirect),
    .i_push  (push),
    .i_wdata (wentry),
    .i_pop   (pop),
    .o_rdata (head),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (fifo_count < DEPTH_C) begin
          state_d = ST_WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      ST_WAIT: begin
        if (i_Redirect) begin
          // A request cannot be withdrawn; without an ack it must be drained.
          fetch_pc_d = redirect_pc;
          state_d    = imem.IMEM_ack ? ST_IDLE : ST_DROP;
        end else if (imem.IMEM_ack) begin
          fetch_pc_d = addr_inc;
          if (count_after < DEPTH_C) begin
            addr_d = addr_inc;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (i_Redirect)    fetch_pc_d = redirect_pc;
        if (imem.IMEM_ack) state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= (state_d != ST_IDLE);
    end
  end

  assign imem.IMEM_req  = req_q;
  assign imem.IMEM_addr = addr_q;

  assign o_Valid = !fifo_empty;
  assign o_Instr = fifo_empty ? NOP_INSTR : head.instr;
  assign o_PC    = fifo_empty ? '0 : head.pc;

  // The FIFO's own full flag is redundant with count-gated issue.
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Self-checking bench for instr_fetch. A queue-based model of the
//             expected instruction stream (program order of fetched PCs)
//             predicts decode outputs and request addresses every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redir;
  logic [31:0] redir_pc;
  logic [31:0] o_instr, o_pc;
  logic        o_valid;

  instr_fetch_if imem ();

  instr_fetch #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (DEPTH),
    .NOP_INSTR  (NOP_INSTR)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .imem         (imem.master),
    .i_Stall      (stall),
    .i_Redirect   (redir),
    .i_RedirectPC (redir_pc),
    .o_Instr      (o_instr),
    .o_PC         (o_pc),
    .o_Valid      (o_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: PCs decode should see, in order; next address to fetch.
  logic [31:0] exp_q[$];
  logic [31:0] next_fetch;
  logic        stale;       // outstanding request was overtaken by a redirect
  logic        prev_req, prev_ack, prev_rst;
  logic [31:0] prev_addr;
  int          lat_cnt, lat_lo, lat_hi;
  int          n_push;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One clock cycle; entered and left at posedge+1.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt,
                       input logic rs, input logic spur_ack);
    logic        ack;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr;
    req  = imem.IMEM_req;
    addr = imem.IMEM_addr;

    // Decode-side outputs against the model head.
    if (exp_q.size() > 0) begin
      chk("valid", o_valid, 1'b1);
      chk("pc", o_pc, exp_q[0]);
      chk("instr", o_instr, imem_word(exp_q[0]));
    end else begin
      chk("valid", o_valid, 1'b0);
      chk("nop", o_instr, NOP_INSTR);
      chk("pc_empty", o_pc, 32'h0);
    end
    if (prev_rst) begin
      chk("rst_req", req, 1'b0);
      chk("rst_addr", addr, RESET_PC);
    end

    // Memory responder.
    ack  = 1'b0;
    data = $urandom;
    if (req) begin
      if (!prev_req || prev_ack) begin
        chk("req_addr", addr, next_fetch);
        lat_cnt = $urandom_range(lat_hi, lat_lo);
      end else begin
        chk("addr_hold", addr, prev_addr);
      end
      if (lat_cnt == 0) begin
        ack  = 1'b1;
        data = imem_word(addr);
      end else begin
        lat_cnt--;
      end
    end
    if (spur_ack) ack = 1'b1;

    stall         = st;
    redir         = rd;
    redir_pc      = tgt;
    rst           = rs;
    imem.IMEM_ack  = ack;
    imem.IMEM_data = data;

    // Model update for this edge.
    if (rs) begin
      exp_q.delete();
      next_fetch = RESET_PC;
      stale      = 1'b0;
    end else if (rd) begin
      exp_q.delete();
      next_fetch = {tgt[31:2], 2'b00};
      if (req) stale = !ack;
    end else begin
      if (exp_q.size() > 0 && !st) void'(exp_q.pop_front());
      if (req && ack) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          chk("fifo_room", 32'(exp_q.size() < DEPTH), 32'd1);
          exp_q.push_back(addr);
          next_fetch = addr + 32'd4;
          n_push++;
        end
      end
    end

    prev_req  = rs ? 1'b0 : req;
    prev_ack  = req && ack;
    prev_addr = addr;
    prev_rst  = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int          pushes0;
    bit          found;
    logic [31:0] tgt;
    rst = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = '0;
    imem.IMEM_ack = 1'b0; imem.IMEM_data = '0;
    exp_q.delete(); next_fetch = RESET_PC; stale = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0; prev_rst = 1'b0;
    lat_cnt = 0; lat_lo = 0; lat_hi = 0; n_push = 0;
    repeat (2) @(posedge clk);
    #1;

    // 1: zero-wait memory, no stall -> one instruction per cycle.
    do_reset();
    chk("t1_req_c0", imem.IMEM_req, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t1_req_c1", imem.IMEM_req, 1'b1);
    chk("t1_addr_c1", imem.IMEM_addr, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t1_valid_c2", o_valid, 1'b1);
    chk("t1_pc_c2", o_pc, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t1_pc_c3", o_pc, 32'h4);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t1_pc_c4", o_pc, 32'h8);
    run(4);

    // 2: stall for 6 cycles -> exactly DEPTH words accepted.
    do_reset();
    pushes0 = n_push;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t2_acks", 32'(n_push - pushes0), 32'(DEPTH));
    chk("t2_req_off", imem.IMEM_req, 1'b0);
    chk("t2_pc_hold", o_pc, 32'h0);
    run(6);

    // 3: 3-cycle latency, redirect one cycle after the request for 0x8.
    do_reset();
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (imem.IMEM_req && imem.IMEM_addr == 32'h8) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("t3_found", 32'(found), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    chk("t3_req_held", imem.IMEM_req, 1'b1);
    chk("t3_addr_held", imem.IMEM_addr, 32'h8);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (o_valid) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("t3_valid_seen", 32'(found), 32'd1);
    chk("t3_first_pc", o_pc, 32'h100);
    run(4);

    // 4: redirect to 0x203 in the same cycle as the ack for 0x10.
    do_reset();
    lat_lo = 0; lat_hi = 0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (imem.IMEM_req && imem.IMEM_addr == 32'h10) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("t4_found", 32'(found), 32'd1);
    cycle(1'b0, 1'b1, 32'h203, 1'b0, 1'b0);
    chk("t4_empty", o_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem.IMEM_req) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("t4_req_seen", 32'(found), 32'd1);
    chk("t4_addr", imem.IMEM_addr, 32'h200);
    run(4);

    // 5: reset with a request outstanding; its late ack must be ignored.
    do_reset();
    lat_lo = 20; lat_hi = 20;
    run(3);
    chk("t5_pending", imem.IMEM_req, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    lat_lo = 0; lat_hi = 0;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("t5_valid", o_valid, 1'b0);
    chk("t5_req", imem.IMEM_req, 1'b1);
    chk("t5_addr", imem.IMEM_addr, RESET_PC);
    run(4);

    // 6: address wrap at the top of the address space.
    do_reset();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (o_valid) found = 1'b1;
      else cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("t6_valid_seen", 32'(found), 32'd1);
    chk("t6_pc_top", o_pc, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("t6_pc_wrap", o_pc, 32'h0);
    run(4);

    // Random traffic: latency, stall and redirect all randomised.
    do_reset();
    lat_lo = 0; lat_hi = 3;
    pushes0 = n_push;
    for (int i = 0; i < 800; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, tgt, 1'b0, 1'b0);
    end
    chk("rand_progress", 32'(n_push - pushes0 > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the main decode/control stage.
- Holds the fetch PC and issues word requests to instruction memory over a req/ack handshake, with at most one request outstanding.
- Buffers returned instructions in a small FIFO and presents {instruction, PC, valid} to decode.
- Honours decode stall, and flushes and redirects on branch, jump or exception.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.
- NOP_INSTR, 32'h0000_0013, value driven on o_Instr when no valid entry (addi x0,x0,0).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- o_IMEM_req  out  1  request valid; held high until i_IMEM_ack.
- o_IMEM_addr  out  32  word address of request; stable while o_IMEM_req high.
- i_IMEM_ack  in  1  one-cycle pulse; i_IMEM_data valid in same cycle.
- i_IMEM_data  in  32  returned instruction word.
- i_Stall  in  1  decode cannot accept this cycle.
- i_Redirect  in  1  flush and restart fetch (taken branch, jump, exception or trap).
- i_RedirectPC  in  32  new fetch target; bits [1:0] ignored (treated as 0).
- o_Instr  out  32  FIFO head instruction, or NOP_INSTR when empty.
- o_PC  out  32  PC of FIFO head, or 32'h0 when empty.
- o_Valid  out  1  FIFO head valid for decode.

Behaviour:
Reset (i_rst sampled high):
- fetch_pc = RESET_PC; FIFO empty; state = IDLE.
- Outputs: o_IMEM_req = 0, o_IMEM_addr = RESET_PC, o_Valid = 0, o_Instr = NOP_INSTR, o_PC = 0.
- An ack arriving during or after reset with no request outstanding is ignored.

State machine:
- States are IDLE, WAIT and DROP. o_IMEM_req = (state == WAIT || state == DROP).
- o_IMEM_addr = address latched at issue (addr_q).
- IDLE -> WAIT when occupancy < FIFO_DEPTH and no i_Redirect. On entry: addr_q = fetch_pc.
- WAIT, no ack: hold the request.
- WAIT, ack, no redirect:
  - Push {addr_q, i_IMEM_data}; fetch_pc = addr_q + 4, wrapping modulo 2^32.
  - If occupancy after this cycle's push and pop < FIFO_DEPTH: stay in WAIT and set addr_q = addr_q + 4 (back-to-back issue). Otherwise go to IDLE.
- WAIT, no ack, i_Redirect: go to DROP, because the request cannot be withdrawn. Keep addr_q unchanged.
- DROP, ack: discard data; go to IDLE. No push.
- DROP, no ack: stay in DROP.

Redirect handling:
- In the i_Redirect cycle: FIFO cleared, fetch_pc = {i_RedirectPC[31:2], 2'b00}.
- Any pop or push in that cycle is cancelled.
- An ack in the same cycle as a redirect (in WAIT) is discarded; state goes to IDLE.
- A redirect while in DROP only updates fetch_pc; state stays DROP.
- First request to the new target is issued the cycle after the redirect, or the cycle after the dropped ack.

Decode interface:
- o_Valid = FIFO not empty. o_Instr and o_PC come from the head entry.
- Pop when o_Valid && !i_Stall && !i_Redirect.
- Push and pop in the same cycle is legal; occupancy is unchanged.
- Push into a full FIFO cannot occur, because issue is gated by occupancy; the bench asserts this.

Timing:
- Latency: ack in cycle N gives o_Valid with that word in cycle N+1 (registered FIFO).
- Throughput: 1 instruction per cycle with a zero-wait memory (ack in the same cycle as the request).
- First request is visible in cycle 1 after reset deasserts.

Decomposition:
- Shared package: NOP_INSTR constant, state encoding typedef (IDLE/WAIT/DROP), XLEN=32 constant.
- One natural sub-module: fetch_fifo, a synchronous FIFO of {pc, instr} with push, pop, flush, count, full and empty.
- The FSM and PC logic stay in instr_fetch.

Test Plan:
1. Reset, zero-wait memory (ack same cycle as req), i_Stall=0 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; o_Valid from cycle 2 with o_PC 0x0, 0x4, 0x8 and the matching data.
2. i_Stall held high 6 cycles, zero-wait memory -> exactly FIFO_DEPTH (2) acks accepted, then o_IMEM_req=0; o_PC stays 0x0; after release, order 0x0, 0x4, 0x8 with no loss or duplication.
3. Memory with 3-cycle ack latency, i_Redirect to 0x100 one cycle after req at 0x8 -> req stays at 0x8 until ack, data discarded, next req at 0x100; o_PC never shows 0x8; first valid o_PC is 0x100.
4. i_Redirect to 0x203 in the same cycle as an ack for 0x10 -> 0x10 word dropped, FIFO empty next cycle, next request address 0x200.
5. i_rst asserted while a request is outstanding, then the late ack arrives -> the ack is ignored, o_Valid=0, and the next request is at RESET_PC.
6. Redirect to 0xFFFF_FFFC, zero-wait memory -> following request address wraps to 0x0000_0000; o_PC sequence 0xFFFF_FFFC, 0x0.
